// File: rtl/key_event_gen.sv
// key_event_gen: synchronised, debounced buttons turned into one-cycle key events.
// Define KEY_AUTOREPEAT_EN to add per-arrow auto-repeat while a key is held.
module key_event_gen #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] btn_n,
  input  logic       btnA_n,
  output logic [3:0] keys,
  output logic       A
);

  localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY)
                        ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_P  = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
  localparam int CW     = $clog2(MAX_P) + 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Bit 4 carries the select button; all levels are pressed-high internally.
  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic [4:0]    db;
  logic [4:0]    db_q;
  logic [CW-1:0] cnt [5];
  logic [4:0]    press;
  logic [3:0]    pend;
  logic [3:0]    low;
  logic [3:0]    rep_set;
  logic          a_pend;

  assign press = db & ~db_q;
  assign low   = pend & (~pend + 4'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      sync1 <= ~{btnA_n, btn_n};
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          db[i]  <= ~db[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RR_LAST = CW'(REPEAT_RATE - 1);

  logic [CW-1:0] rcnt [4];
  logic [3:0]    rlater;
  logic [3:0]    held;

  assign held = db[3:0] & db_q[3:0];

  always_comb begin
    rep_set = '0;
    for (int i = 0; i < 4; i++)
      rep_set[i] = held[i] &&
        (rcnt[i] == (rlater[i] ? RR_LAST : RD_LAST));
  end

  // First period is the long delay; rlater switches to the repeat rate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rlater <= '0;
      for (int i = 0; i < 4; i++) rcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!held[i]) begin
          rcnt[i]   <= '0;
          rlater[i] <= 1'b0;
        end else if (rep_set[i]) begin
          rcnt[i]   <= '0;
          rlater[i] <= 1'b1;
        end else begin
          rcnt[i] <= rcnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign rep_set = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend   <= '0;
      a_pend <= 1'b0;
      keys   <= '0;
      A      <= 1'b0;
    end else begin
      keys   <= low;
      pend   <= (pend & ~low) | press[3:0] | rep_set;
      a_pend <= press[4];
      A      <= a_pend;
    end
  end

endmodule
